wall_column_renderer: RTL and testbench
=======================================

# wall_column_renderer

- Downstream consumer of the trace buffer; sits between the trace buffer and the VGA output pins.
- For each visible pixel it issues a registered read of the current column's trace entry (height, side, tex) and compares the wall half-height against the current row.
- Emits a 6-bit RGB pixel plus sync/visible signals delayed to match its 2-cycle pipeline.
- Never writes the trace buffer.

## Interface
Parameters:
- H_VISIBLE, 640, visible columns; reads issued only for hpos < H_VISIBLE
- V_CENTER, 240, horizon row
- MAX_HALF, 240, half-height clamp (pixels)

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock, async active-high reset
- hpos  in  10  current column from sync generator
- vpos  in  10  current row
- visible_in  in  1  display-enable for (hpos, vpos)
- hsync_in  in  1  raw horizontal sync
- vsync_in  in  1  raw vertical sync
- tb_cs  out  1  trace buffer chip select
- tb_oe  out  1  trace buffer output enable
- tb_we  out  1  trace buffer write enable; constant 0
- tb_column  out  10  trace buffer address
- tb_distance  in  16  read data: wall half-height, unsigned 10.6 fixed point
- tb_side  in  1  read data: wall face (0 = X-facing, 1 = Y-facing)
- tb_tex  in  6  read data: texture u coordinate
- rgb  out  6  {R[1:0], G[1:0], B[1:0]}
- hsync_out, vsync_out, visible_out  out  1 each  inputs delayed 2 cycles

## Operation
- FSM states:
  - BLANK (reset state): visible_in = 0 or hpos ≥ H_VISIBLE.
  - LEAD: first cycle of a visible run.
  - RUN: subsequent visible cycles.
- Transitions:
  - BLANK→LEAD on visible_in = 1 with hpos < H_VISIBLE.
  - LEAD→RUN unconditionally if still visible.
  - LEAD/RUN→BLANK when visible_in = 0 or hpos ≥ H_VISIBLE.
- Read request, cycle t, combinational:
  - In LEAD/RUN and on the BLANK→LEAD cycle: tb_cs = tb_oe = 1, tb_column = hpos.
  - Otherwise tb_cs = tb_oe = 0 and tb_column holds its last value.
- Stage 1, t+1:
  - Trace data is valid.
  - vpos and a valid bit are carried in pipeline registers.
- Half-height:
  - h = tb_distance[15:6], then clamped to MAX_HALF when tb_distance[15:6] > MAX_HALF.
  - Fraction bits are ignored.
- Wall test: wall when V_CENTER − h ≤ vpos < V_CENTER + h. Use 11-bit signed arithmetic, so h = 0 gives no wall.
- Colour, registered at t+2:
  - not valid → 000000
  - wall, side = 0 → 110000
  - wall, side = 1 → 100000
  - non-wall, vpos < V_CENTER (ceiling) → 010101
  - non-wall, vpos ≥ V_CENTER (floor) → 101010
- Sync: hsync/vsync/visible pass through a 2-deep shift register so they align with rgb.
- Reset mid-line: the FSM returns to BLANK and rgb goes to 0 immediately. The first pixel after reset release follows the normal pipeline.

## Timing
- Latency: 2 clocks from (hpos, vpos, visible_in) to rgb/visible_out/sync outputs.
- Throughput: one pixel per clock; one trace read per visible pixel.
- Trace buffer read is registered: data presented in cycle t+1 for an address in cycle t. tb_we is never asserted, so no write collision is possible.
- Reset values (asynchronous):
  - rgb = 0, tb_cs = tb_oe = tb_we = 0, tb_column = 0
  - hsync_out = vsync_out = 0, visible_out = 0
  - FSM = BLANK; all pipeline valid bits = 0
- Boundaries:
  - hpos = 639 issues a read. hpos = 640 issues none, and that pixel's rgb two cycles later is 000000.
  - A visible_in glitch of one cycle yields exactly one read and one coloured pixel.

## Configuration
- TEXTURE_EN defined, wall pixels only:
  - R[1:0] = tex[5:4] ^ vpos[4:3]
  - G[1:0] = tex[3:2] ^ vpos[2:1]
  - B = {side, tex[0]}
  - Ceiling/floor colours are unchanged.
- TEXTURE_EN undefined: flat side colours as in Operation; tb_tex is ignored.

## Test plan
- Reset asserted mid-line with hpos = 100 → same cycle: rgb = 0, tb_cs = 0, visible_out = 0; after release, first rgb valid 2 cycles after the first visible pixel.
- Column 5 holds distance = 0x0C80 (h = 50), side = 0; vpos = 200 → rgb at column 5 = 110000. vpos = 189 → 010101. vpos = 290 → 101010 (290 ≥ V_CENTER + h).
- distance = 0xFFFF, side = 1 → h clamps to 240; every row 0..479 is 100000 (no TEXTURE_EN).
- distance = 0x0000 → no wall; vpos = 239 gives 010101, vpos = 240 gives 101010.
- Line sweep hpos 0..799 → tb_cs high exactly for hpos 0..639, tb_column = hpos on those cycles, tb_we never 1; hsync_out equals hsync_in delayed 2.
- TEXTURE_EN defined, tex = 0b101101, side = 1, vpos = 8 inside wall → rgb = {10^01, 11^00, 1 1} = 111111.

Source files
------------

// File: rtl/wall_column_renderer.sv
// wall_column_renderer: reads one trace-buffer entry per visible pixel and shades it as wall, ceiling or floor.
// Optional feature macro TEXTURE_EN: modulate wall pixels by the texture u coordinate and the row.
module wall_column_renderer #(
    parameter int H_VISIBLE = 640,
    parameter int V_CENTER  = 240,
    parameter int MAX_HALF  = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        visible_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        tb_cs,
    output logic        tb_oe,
    output logic        tb_we,
    output logic [9:0]  tb_column,
    input  logic [15:0] tb_distance,
    input  logic        tb_side,
    input  logic [5:0]  tb_tex,
    output logic [5:0]  rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        visible_out
);

    localparam logic [9:0]         H_LIMIT = H_VISIBLE[9:0];
    localparam logic [9:0]         H_CLAMP = MAX_HALF[9:0];
    localparam logic signed [10:0] CENTER  = V_CENTER[10:0];

    typedef enum logic [1:0] {BLANK, LEAD, RUN} state_t;

    state_t      state;
    logic        in_active;
    logic        read_req;
    logic [9:0]  last_column;
    logic        s1_valid;
    logic [9:0]  s1_vpos;
    logic [1:0]  hsync_dly;
    logic [1:0]  vsync_dly;
    logic [1:0]  visible_dly;
    logic [9:0]  raw_half;
    logic [9:0]  half;
    logic signed [10:0] half_s;
    logic signed [10:0] row;
    logic signed [10:0] wall_top;
    logic signed [10:0] wall_bottom;
    logic        is_wall;
    logic [5:0]  next_rgb;
    logic        unused_bits;

    assign in_active = visible_in && (hpos < H_LIMIT);

    // A read goes out on every visible pixel, including the BLANK->LEAD cycle; reset silences it at once.
    assign read_req  = in_active && !reset;
    assign tb_cs     = read_req;
    assign tb_oe     = read_req;
    assign tb_we     = 1'b0;
    assign tb_column = reset ? 10'd0 : (read_req ? hpos : last_column);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BLANK;
        end else begin
            case (state)
                BLANK:   state <= in_active ? LEAD : BLANK;
                LEAD:    state <= in_active ? RUN  : BLANK;
                RUN:     state <= in_active ? RUN  : BLANK;
                default: state <= BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_column <= '0;
            s1_valid    <= 1'b0;
            s1_vpos     <= '0;
            hsync_dly   <= '0;
            vsync_dly   <= '0;
            visible_dly <= '0;
        end else begin
            if (read_req)
                last_column <= hpos;
            s1_valid    <= read_req;
            s1_vpos     <= vpos;
            hsync_dly   <= {hsync_dly[0], hsync_in};
            vsync_dly   <= {vsync_dly[0], vsync_in};
            visible_dly <= {visible_dly[0], visible_in};
        end
    end

    // Signed 11-bit bounds so a zero half-height collapses the wall to an empty interval.
    always_comb begin
        raw_half    = tb_distance[15:6];
        half        = (raw_half > H_CLAMP) ? H_CLAMP : raw_half;
        half_s      = {1'b0, half};
        row         = {1'b0, s1_vpos};
        wall_top    = CENTER - half_s;
        wall_bottom = CENTER + half_s;
        is_wall     = (row >= wall_top) && (row < wall_bottom);
    end

    always_comb begin
        next_rgb = 6'b000000;
        if (!s1_valid)
            next_rgb = 6'b000000;
        else if (is_wall) begin
`ifdef TEXTURE_EN
            next_rgb = {tb_tex[5:4] ^ s1_vpos[4:3], tb_tex[3:2] ^ s1_vpos[2:1], tb_side, tb_tex[0]};
`else
            next_rgb = tb_side ? 6'b100000 : 6'b110000;
`endif
        end else if (row < CENTER)
            next_rgb = 6'b010101;
        else
            next_rgb = 6'b101010;
    end

`ifdef TEXTURE_EN
    assign unused_bits = ^{tb_distance[5:0], tb_tex[1]};
`else
    assign unused_bits = ^{tb_distance[5:0], tb_tex};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rgb <= '0;
        else
            rgb <= next_rgb;
    end

    assign hsync_out   = hsync_dly[1];
    assign vsync_out   = vsync_dly[1];
    assign visible_out = visible_dly[1];

endmodule

// File: tb/tb_wall_column_renderer.sv
// Self-checking bench for wall_column_renderer: a trace-buffer memory model plus a
// pixel-level reference that predicts each rgb/sync output two clocks after its inputs.
module tb_wall_column_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hpos, vpos;
    logic        visible_in, hsync_in, vsync_in;
    logic        tb_cs, tb_oe, tb_we;
    logic [9:0]  tb_column;
    logic [15:0] tb_distance;
    logic        tb_side;
    logic [5:0]  tb_tex;
    logic [5:0]  rgb;
    logic        hsync_out, vsync_out, visible_out;

    wall_column_renderer dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .visible_in(visible_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .tb_cs(tb_cs), .tb_oe(tb_oe), .tb_we(tb_we), .tb_column(tb_column),
        .tb_distance(tb_distance), .tb_side(tb_side), .tb_tex(tb_tex),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .visible_out(visible_out)
    );

    always #5 clk = ~clk;

    logic [15:0] mem_dist [1024];
    logic        mem_side [1024];
    logic [5:0]  mem_tex  [1024];

    // Registered-read trace buffer: address in cycle t, data in cycle t+1.
    always @(posedge clk) begin
        if (tb_cs && tb_oe) begin
            tb_distance <= mem_dist[tb_column];
            tb_side     <= mem_side[tb_column];
            tb_tex      <= mem_tex[tb_column];
        end
    end

    typedef struct {
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        logic       vis;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_last_col = 0;
    int   prev_last_col;
    int   cur_h;
    bit   cur_exp_cs;
    logic [5:0] obs_rgb, exp_rgb;
    logic obs_hs, obs_vs, obs_vis, obs_cs, obs_oe, obs_we;
    logic [9:0] obs_col;
    logic exp_hs, exp_vs, exp_vis;

    function automatic logic [5:0] model_rgb(input int h, input int v, input bit vis);
        int half, tex, side;
        if (!vis || h >= 640) return 6'b000000;
        half = int'(mem_dist[h]) / 64;
        if (half > 240) half = 240;
        tex  = int'(mem_tex[h]);
        side = int'(mem_side[h]);
        if (v >= 240 - half && v < 240 + half) begin
`ifdef TEXTURE_EN
            return 6'(((((tex / 16) % 4) ^ ((v / 8) % 4)) * 16) + ((((tex / 4) % 4) ^ ((v / 2) % 4)) * 4) + side * 2 + (tex % 2));
`else
            return (side == 1) ? 6'b100000 : 6'b110000;
`endif
        end
        return (v < 240) ? 6'b010101 : 6'b101010;
    endfunction

    task automatic seed_pipeline();
        exp_t z;
        z.rgb = '0; z.hs = 1'b0; z.vs = 1'b0; z.vis = 1'b0;
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
        model_last_col = 0;
    endtask

    task automatic drive_idle();
        hpos = '0; vpos = '0; visible_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    endtask

    // Drives one pixel, then captures outputs mid-cycle alongside the prediction due now.
    task automatic tick(input int h, input int v, input bit vis, input bit hs, input bit vs);
        exp_t e;
        @(posedge clk);
        #1;
        hpos = h[9:0]; vpos = v[9:0]; visible_in = vis; hsync_in = hs; vsync_in = vs;
        cur_h = h;
        cur_exp_cs = vis && (h < 640);
        prev_last_col = model_last_col;
        if (cur_exp_cs) model_last_col = h;
        e.rgb = model_rgb(h, v, vis); e.hs = hs; e.vs = vs; e.vis = vis;
        exp_q.push_back(e);
        @(negedge clk);
        obs_rgb = rgb; obs_hs = hsync_out; obs_vs = vsync_out; obs_vis = visible_out;
        obs_cs = tb_cs; obs_oe = tb_oe; obs_we = tb_we; obs_col = tb_column;
        e = exp_q.pop_front();
        exp_rgb = e.rgb; exp_hs = e.hs; exp_vs = e.vs; exp_vis = e.vis;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (rgb !== 6'b0 || tb_cs !== 1'b0 || tb_oe !== 1'b0 || tb_we !== 1'b0 || tb_column !== 10'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: rgb=%b cs=%b oe=%b we=%b col=%0d, required all 0", rgb, tb_cs, tb_oe, tb_we, tb_column);
        end
        n_checks++;
        if (hsync_out !== 1'b0 || vsync_out !== 1'b0 || visible_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_sync: hs=%b vs=%b vis=%b, required 0", hsync_out, vsync_out, visible_out);
        end
        @(negedge clk);
        reset = 1'b0;
        seed_pipeline();
        for (int h = 94; h < 100; h++) begin
            tick(h, 150, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs_rgb !== exp_rgb) begin
                n_fail++;
                $display("[TB] FAIL preline_rgb h=%0d: got %b required %b", h, obs_rgb, exp_rgb);
            end
        end
        @(posedge clk);
        #1;
        hpos = 10'd100; vpos = 10'd150; visible_in = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (rgb !== 6'b0 || tb_cs !== 1'b0 || visible_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midline_reset: rgb=%b cs=%b vis_out=%b, required 0", rgb, tb_cs, visible_out);
        end
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seed_pipeline();
        for (int i = 0; i < 9; i++) begin
            if (i >= 2 && i < 6) tick(99 + i, 150, 1'b1, 1'b0, 1'b0);
            else tick(0, 0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_rgb !== exp_rgb || obs_vis !== exp_vis) begin
                n_fail++;
                $display("[TB] FAIL post_reset i=%0d: rgb=%b vis=%b required rgb=%b vis=%b", i, obs_rgb, obs_vis, exp_rgb, exp_vis);
            end
        end
    endtask

    task automatic test_wall_rows();
        int rows [3] = '{200, 189, 290};
        logic [5:0] lit [3];
`ifdef TEXTURE_EN
        lit[0] = 6'b100000;
`else
        lit[0] = 6'b110000;
`endif
        lit[1] = 6'b010101;
        lit[2] = 6'b101010;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                if (i < 6) tick(3 + i, rows[r], 1'b1, 1'b0, 1'b0);
                else tick(0, 0, 1'b0, 1'b0, 1'b0);
                n_checks++;
                if (obs_rgb !== exp_rgb) begin
                    n_fail++;
                    $display("[TB] FAIL wall_rows v=%0d i=%0d: got %b required %b", rows[r], i, obs_rgb, exp_rgb);
                end
                if (i == 4) begin
                    n_checks++;
                    if (obs_rgb !== lit[r]) begin
                        n_fail++;
                        $display("[TB] FAIL col5 v=%0d: got %b required %b", rows[r], obs_rgb, lit[r]);
                    end
                end
            end
        end
    endtask

    task automatic test_clamp();
        for (int v = 0; v < 482; v++) begin
            if (v < 480) tick(10, v, 1'b1, 1'b0, 1'b0);
            else tick(0, 0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_rgb !== exp_rgb) begin
                n_fail++;
                $display("[TB] FAIL clamp v=%0d: got %b required %b", v, obs_rgb, exp_rgb);
            end
`ifndef TEXTURE_EN
            if (v >= 2) begin
                n_checks++;
                if (obs_rgb !== 6'b100000) begin
                    n_fail++;
                    $display("[TB] FAIL clamp_flat row=%0d: got %b required 100000", v - 2, obs_rgb);
                end
            end
`endif
        end
    endtask

    task automatic test_zero_height();
        logic [5:0] lit [2] = '{6'b010101, 6'b101010};
        for (int i = 0; i < 4; i++) begin
            if (i < 2) tick(20, 239 + i, 1'b1, 1'b0, 1'b0);
            else tick(0, 0, 1'b0, 1'b0, 1'b0);
            if (i >= 2) begin
                n_checks++;
                if (obs_rgb !== lit[i - 2]) begin
                    n_fail++;
                    $display("[TB] FAIL zero_height v=%0d: got %b required %b", 237 + i, obs_rgb, lit[i - 2]);
                end
            end
        end
    endtask

    task automatic test_line_sweep();
        int v;
        bit vs;
        for (int line = 0; line < 2; line++) begin
            v  = $urandom_range(0, 479);
            vs = 1'($urandom_range(0, 1));
            for (int h = 0; h < 800; h++) begin
                tick(h, v, h < 700, (h >= 656 && h < 752), vs);
                n_checks++;
                if (obs_cs !== cur_exp_cs || obs_oe !== cur_exp_cs || obs_we !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL sweep_strobe h=%0d: cs=%b oe=%b we=%b required cs=oe=%b we=0", h, obs_cs, obs_oe, obs_we, cur_exp_cs);
                end
                n_checks++;
                if (obs_col !== 10'(cur_exp_cs ? cur_h : prev_last_col)) begin
                    n_fail++;
                    $display("[TB] FAIL sweep_column h=%0d: got %0d required %0d", h, obs_col, cur_exp_cs ? cur_h : prev_last_col);
                end
                n_checks++;
                if (obs_rgb !== exp_rgb || obs_hs !== exp_hs || obs_vs !== exp_vs || obs_vis !== exp_vis) begin
                    n_fail++;
                    $display("[TB] FAIL sweep_out h=%0d: rgb=%b hs=%b vs=%b vis=%b required %b %b %b %b",
                             h, obs_rgb, obs_hs, obs_vs, obs_vis, exp_rgb, exp_hs, exp_vs, exp_vis);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int reads = 0;
        int h = $urandom_range(0, 639);
        int v = $urandom_range(0, 479);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) tick(h, v, 1'b1, 1'b0, 1'b0);
            else tick(h, v, 1'b0, 1'b0, 1'b0);
            if (obs_cs === 1'b1) reads++;
            n_checks++;
            if (obs_rgb !== exp_rgb || obs_vis !== exp_vis) begin
                n_fail++;
                $display("[TB] FAIL glitch i=%0d: rgb=%b vis=%b required %b %b", i, obs_rgb, obs_vis, exp_rgb, exp_vis);
            end
        end
        n_checks++;
        if (reads != 1) begin
            n_fail++;
            $display("[TB] FAIL glitch_reads: got %0d required 1", reads);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (obs_rgb !== exp_rgb || obs_hs !== exp_hs || obs_vs !== exp_vs || obs_vis !== exp_vis || obs_cs !== cur_exp_cs) begin
                n_fail++;
                $display("[TB] FAIL random i=%0d h=%0d: rgb=%b hs=%b vs=%b vis=%b cs=%b required %b %b %b %b %b",
                         i, cur_h, obs_rgb, obs_hs, obs_vs, obs_vis, obs_cs, exp_rgb, exp_hs, exp_vs, exp_vis, cur_exp_cs);
            end
        end
    endtask

    task automatic test_texture();
        logic [5:0] lit;
`ifdef TEXTURE_EN
        lit = 6'b111111;
`else
        lit = 6'b100000;
`endif
        for (int i = 0; i < 4; i++) begin
            if (i < 2) tick(30, 8, 1'b1, 1'b0, 1'b0);
            else tick(0, 0, 1'b0, 1'b0, 1'b0);
            if (i >= 2) begin
                n_checks++;
                if (obs_rgb !== lit) begin
                    n_fail++;
                    $display("[TB] FAIL texture i=%0d: got %b required %b", i, obs_rgb, lit);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        for (int i = 0; i < 1024; i++) begin
            mem_dist[i] = 16'($urandom_range(0, 65535));
            mem_side[i] = 1'($urandom_range(0, 1));
            mem_tex[i]  = 6'($urandom_range(0, 63));
        end
        mem_dist[5]  = 16'h0C80; mem_side[5]  = 1'b0; mem_tex[5]  = 6'b110000;
        mem_dist[10] = 16'hFFFF; mem_side[10] = 1'b1;
        mem_dist[20] = 16'h0000;
        mem_dist[30] = 16'hFFFF; mem_side[30] = 1'b1; mem_tex[30] = 6'b101101;
        test_reset();
        test_wall_rows();
        test_clamp();
        test_zero_height();
        test_line_sweep();
        test_glitch();
        test_random();
        test_texture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
